serial_out_driver: RTL and testbench
====================================

Name: serial_out_driver

Overview:
- Consumes the parallel register value produced by the Wishbone output register and shifts it serially into an external shift-register/latch chip (74HC595-style: serial clock, serial data, latch).
- Starts a transfer whenever the parallel value differs from what was last latched externally, or when a refresh is forced.
- Sits directly downstream of the output register, between it and the board pins.

Parameters:
- DATA_WIDTH, 32, width of the parallel input and of one serial frame.
- CLK_DIV, 4, system clocks per serial-clock half period. Legal values are 1 and above.
- MSB_FIRST, 1, 1 shifts bit DATA_WIDTH-1 first; 0 shifts bit 0 first.

Ports:
- clk_i  in  1  system clock. All logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_i  in  DATA_WIDTH  parallel value (output-register `out`).
- force_i  in  1  single-cycle request to re-send the current data_i even if it is unchanged.
- busy_o  out  1  high while a frame is being shifted or latched.
- done_o  out  1  one-cycle pulse when a frame has been latched externally.
- shown_o  out  DATA_WIDTH  value last latched into the external chip.
- ser_clk_o  out  1  serial clock to the external chip.
- ser_dat_o  out  1  serial data to the external chip.
- ser_latch_o  out  1  storage latch strobe to the external chip.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; all outputs go to 0; shown_o goes to 0.
  - The internal pending flag is set to 1, so the first frame is sent after reset is released, because the external chip state is unknown.
- Divider: counter div_cnt counts 0..CLK_DIV-1 in the shift/latch states. A "tick" is asserted when div_cnt reaches CLK_DIV-1; div_cnt then wraps to 0.
- IDLE:
  - ser_clk_o, ser_latch_o and busy_o are 0.
  - The start condition is (data_i != shown_o) OR pending OR force_i.
  - On start: snapshot <= data_i, bit_cnt <= DATA_WIDTH, pending <= 0, next state SHIFT_LO. busy_o goes high on the following cycle.
- SHIFT_LO:
  - ser_clk_o = 0.
  - ser_dat_o = snapshot[DATA_WIDTH-1] if MSB_FIRST, otherwise snapshot[0].
  - On tick: go to SHIFT_HI.
- SHIFT_HI:
  - ser_clk_o = 1; ser_dat_o is held stable.
  - On tick: shift snapshot toward the output bit and decrement bit_cnt.
  - If bit_cnt was 1, go to LATCH; otherwise go to SHIFT_LO.
- LATCH:
  - ser_clk_o = 0, ser_latch_o = 1 for CLK_DIV cycles.
  - On tick: shown_o <= the value captured at start, and go to DONE.
- DONE:
  - For one cycle: done_o = 1, busy_o = 0, ser_latch_o = 0.
  - Then go to IDLE. The start condition is first re-evaluated in IDLE on the next cycle.
- Timing:
  - busy_o is high for exactly 2*DATA_WIDTH*CLK_DIV + CLK_DIV cycles per frame.
  - Minimum gap between frames is 2 cycles (the DONE cycle plus the IDLE evaluation cycle).
- ser_dat_o changes only on the SHIFT_HI→SHIFT_LO and IDLE→SHIFT_LO transitions. It never changes while ser_clk_o = 1.
- Boundary conditions:
  - data_i changing mid-frame: the frame is not disturbed, because the snapshot is used. The mismatch with shown_o then triggers a new frame after DONE.
  - force_i while busy: sets pending = 1, which is sticky. Exactly one extra frame follows, regardless of how many force pulses arrived.
  - force_i in the same IDLE cycle as a data change: one frame only.
  - reset_n asserted mid-frame: the frame is abandoned immediately with all outputs at reset values, and pending is set.
- Width rules:
  - bit_cnt is sized by oitBits(DATA_WIDTH+1).
  - div_cnt is sized by oitBits(CLK_DIV), with a minimum width of 1.

Decomposition:
- Shared package serial_out_pkg:
  - state enum {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} as 3-bit logic.
  - localparam helpers for the counter widths, using oitBits.
- One sub-module, serial_tick_gen:
  - Parameterised by CLK_DIV; ports clk_i, reset_n, run_i, tick_o.
  - Counter is cleared when run_i = 0.
- The top level holds the FSM, snapshot shifter, bit counter and pending flag.

Test Plan:
1. Release reset with DATA_WIDTH=8, CLK_DIV=1, data_i=8'hA5 → one frame; busy_o high for 17 cycles; ser_dat_o on rising ser_clk edges reads 1,0,1,0,0,1,0,1; one ser_latch_o pulse; done_o pulse; shown_o=8'hA5.
2. After test 1, hold data_i=8'hA5 for 100 cycles → no further frames; busy_o stays 0.
3. Mid-frame (bit 3), change data_i to 8'h3C → first frame completes and shifts A5; a second frame starts 2 cycles after done_o; final shown_o=8'h3C.
4. Pulse force_i three times during a busy frame → exactly one extra frame with the same data; done_o pulses twice in total.
5. CLK_DIV=4, MSB_FIRST=0, data_i=8'h01 → each ser_clk_o phase lasts 4 cycles; the first bit shifted is 1; busy_o lasts 68 cycles.
6. Assert reset_n low at bit 5 of a frame → ser_clk_o, ser_dat_o, ser_latch_o, busy_o and shown_o all go to 0 immediately; after release, a full frame of the current data_i is sent.

Source files
------------

// File: rtl/serial_out_pkg.sv
// Shared types and width helpers for the serial output driver and its tick generator.
package serial_out_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LATCH    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CLK_DIV    = 4;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int oit_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int bit_cnt_w(input int data_width);
        return oit_bits(data_width + 1);
    endfunction

    function automatic int div_cnt_w(input int clk_div);
        return oit_bits(clk_div);
    endfunction

endpackage

// File: rtl/serial_out_driver_tick.sv
// Serial-clock phase timer: pulses tick_o every CLK_DIV cycles while run_i is high.
module serial_tick_gen
    import serial_out_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic reset_n,
    input  logic run_i,
    output logic tick_o
);

    localparam int CW = div_cnt_w(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!run_i || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick_o = run_i && (r_cnt == LAST);

endmodule

// File: rtl/serial_out_driver.sv
// Shifts the parallel output-register value into a 74HC595-style chain whenever it
// differs from what the chip last latched, or when a refresh is forced.
module serial_out_driver
    import serial_out_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  force_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] shown_o,
    output logic                  ser_clk_o,
    output logic                  ser_dat_o,
    output logic                  ser_latch_o
);

    localparam int BW      = bit_cnt_w(DATA_WIDTH);
    localparam int OUT_BIT = (MSB_FIRST != 0) ? DATA_WIDTH - 1 : 0;

    state_t                r_state;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_pending;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_capt;
    logic [DATA_WIDTH-1:0] r_shown;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_sclk;
    logic                  r_sdat;
    logic                  r_latch;

    logic                  w_run;
    logic                  w_tick;
    logic                  w_start;
    logic                  w_load;
    logic                  w_shift_en;
    logic [DATA_WIDTH-1:0] w_shift_next;

    assign w_run        = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI) ||
                          (r_state == ST_LATCH);
    assign w_start      = (data_i != r_shown) || r_pending || force_i;
    assign w_load       = (r_state == ST_IDLE) && w_start;
    assign w_shift_en   = (r_state == ST_SHIFT_HI) && w_tick;
    assign w_shift_next = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

    serial_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .run_i   (w_run),
        .tick_o  (w_tick)
    );

    // Frame data needs no reset: it is always loaded before it is used.
    always_ff @(posedge clk_i) begin
        if (w_load) begin
            r_shift <= data_i;
            r_capt  <= data_i;
        end else if (w_shift_en) begin
            r_shift <= w_shift_next;
        end
    end

    // Pending comes out of reset set: the external chip content is unknown.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_pending <= 1'b1;
            r_shown   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_sdat    <= 1'b0;
            r_latch   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (force_i && (r_state != ST_IDLE)) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_bit_cnt <= BW'(DATA_WIDTH);
                        r_pending <= 1'b0;
                        r_sdat    <= data_i[OUT_BIT];
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_tick) begin
                        r_sclk  <= 1'b1;
                        r_state <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_tick) begin
                        r_sclk    <= 1'b0;
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                        if (r_bit_cnt == BW'(1)) begin
                            r_latch <= 1'b1;
                            r_state <= ST_LATCH;
                        end else begin
                            r_sdat  <= w_shift_next[OUT_BIT];
                            r_state <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_LATCH: begin
                    if (w_tick) begin
                        r_latch <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_shown <= r_capt;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign shown_o     = r_shown;
    assign ser_clk_o   = r_sclk;
    assign ser_dat_o   = r_sdat;
    assign ser_latch_o = r_latch;

endmodule

// File: tb/tb_serial_out_driver.sv
// Bench for serial_out_driver: instance 0 is 8-bit, CLK_DIV=1, MSB first; instance 1 is 8-bit, CLK_DIV=4, LSB first.
module tb_serial_out_driver;

    localparam int DW = 8;

    logic                clk;
    logic [1:0]          rst_n;
    logic [1:0][DW-1:0]  data;
    logic [1:0]          frc;
    logic [1:0]          busy, done, sclk, sdat, slat;
    logic [1:0][DW-1:0]  shown;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    int frames[2];
    int nbits[2];
    int busy_len[2];
    int hi_len[2];
    int lo_len[2];
    int lat_len[2];
    int last_done_cyc[2];
    int last_gap[2];
    logic [1:0][DW-1:0] bits;
    logic [1:0] first_bit;
    logic [1:0] p_sclk, p_sdat, p_slat, p_busy;

    serial_out_driver #(.DATA_WIDTH(DW), .CLK_DIV(1), .MSB_FIRST(1)) dut_a (
        .clk_i(clk), .reset_n(rst_n[0]), .data_i(data[0]), .force_i(frc[0]),
        .busy_o(busy[0]), .done_o(done[0]), .shown_o(shown[0]),
        .ser_clk_o(sclk[0]), .ser_dat_o(sdat[0]), .ser_latch_o(slat[0])
    );

    serial_out_driver #(.DATA_WIDTH(DW), .CLK_DIV(4), .MSB_FIRST(0)) dut_b (
        .clk_i(clk), .reset_n(rst_n[1]), .data_i(data[1]), .force_i(frc[1]),
        .busy_o(busy[1]), .done_o(done[1]), .shown_o(shown[1]),
        .ser_clk_o(sclk[1]), .ser_dat_o(sdat[1]), .ser_latch_o(slat[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int cd_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Monitor: rebuilds each frame from the serial pins and checks it against the scoreboard.
    initial begin
        for (int k = 0; k < 2; k++) begin
            frames[k] = 0; nbits[k] = 0; busy_len[k] = 0; hi_len[k] = 0; lo_len[k] = 0;
            lat_len[k] = 0; last_done_cyc[k] = 0; last_gap[k] = 0;
        end
        bits = '0; first_bit = '0; p_sclk = '0; p_sdat = '0; p_slat = '0; p_busy = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!rst_n[k]) begin
                    nbits[k] = 0; busy_len[k] = 0; hi_len[k] = 0; lo_len[k] = 0; lat_len[k] = 0;
                end else begin
                    if (sclk[k] && !p_sclk[k]) begin
                        check($sformatf("lo_len%0d", k), lo_len[k], cd_of(k));
                        lo_len[k] = 0;
                        if (nbits[k] == 0) first_bit[k] = sdat[k];
                        if (k == 0) bits[k] = {bits[k][DW-2:0], sdat[k]};
                        else        bits[k] = {sdat[k], bits[k][DW-1:1]};
                        nbits[k]++;
                    end
                    if (sclk[k]) begin
                        hi_len[k]++;
                        if (p_sclk[k]) check($sformatf("dat_stable%0d", k), sdat[k], p_sdat[k]);
                    end
                    if (!sclk[k] && p_sclk[k]) begin
                        check($sformatf("hi_len%0d", k), hi_len[k], cd_of(k));
                        hi_len[k] = 0;
                    end
                    if (busy[k] && !sclk[k] && !slat[k]) lo_len[k]++;
                    if (slat[k]) lat_len[k]++;
                    if (!slat[k] && p_slat[k]) begin
                        check($sformatf("latch_len%0d", k), lat_len[k], cd_of(k));
                        lat_len[k] = 0;
                    end
                    if (busy[k]) busy_len[k]++;
                    if (busy[k] && !p_busy[k]) last_gap[k] = cyc - last_done_cyc[k];
                    if (!busy[k] && p_busy[k]) begin
                        check($sformatf("busy_len%0d", k), busy_len[k], 2*DW*cd_of(k) + cd_of(k));
                        busy_len[k] = 0;
                        lo_len[k] = 0;
                    end
                    if (done[k]) begin
                        logic [DW-1:0] exp_v;
                        frames[k]++;
                        last_done_cyc[k] = cyc;
                        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                            check($sformatf("unexpected_frame%0d", k), 32'd1, 32'd0);
                        end else begin
                            exp_v = (k == 0) ? q0.pop_front() : q1.pop_front();
                            check($sformatf("frame_bits%0d", k), bits[k], exp_v);
                            check($sformatf("nbits%0d", k), nbits[k], DW);
                            check($sformatf("shown_at_done%0d", k), shown[k], exp_v);
                        end
                        nbits[k] = 0;
                    end
                end
                p_sclk[k] = rst_n[k] ? sclk[k] : 1'b0;
                p_sdat[k] = sdat[k];
                p_slat[k] = rst_n[k] ? slat[k] : 1'b0;
                p_busy[k] = rst_n[k] ? busy[k] : 1'b0;
            end
        end
    end

    task automatic wait_frames(input int k, input int target, input int budget);
        int n = 0;
        while (frames[k] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("frames_reached%0d", k), frames[k], target);
    endtask

    task automatic pulse_force(input int k);
        frc[k] = 1'b1;
        @(negedge clk);
        frc[k] = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] dat;
        logic          frc;
        int            nfr;
        logic [DW-1:0] exp_shown;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int base;
        int n;
        vecs[0] = '{dat: 8'h3C, frc: 1'b0, nfr: 1, exp_shown: 8'h3C};
        vecs[1] = '{dat: 8'h3C, frc: 1'b1, nfr: 1, exp_shown: 8'h3C};
        vecs[2] = '{dat: 8'hC3, frc: 1'b1, nfr: 1, exp_shown: 8'hC3};
        vecs[3] = '{dat: 8'hFF, frc: 1'b0, nfr: 1, exp_shown: 8'hFF};
        vecs[4] = '{dat: 8'h00, frc: 1'b0, nfr: 1, exp_shown: 8'h00};
        vecs[5] = '{dat: 8'h80, frc: 1'b0, nfr: 1, exp_shown: 8'h80};
        vecs[6] = '{dat: 8'h01, frc: 1'b0, nfr: 1, exp_shown: 8'h01};
        vecs[7] = '{dat: 8'h01, frc: 1'b0, nfr: 0, exp_shown: 8'h01};

        rst_n = 2'b00;
        frc   = 2'b00;
        data[0] = 8'hA5;
        data[1] = 8'h01;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            check($sformatf("reset_outs%0d", k), {busy[k], done[k], sclk[k], sdat[k], slat[k], shown[k]}, 32'd0);

        // Test 1: first frame after reset
        q0.push_back(8'hA5);
        rst_n[0] = 1'b1;
        wait_frames(0, 1, 100);
        check("shown_A5", shown[0], 8'hA5);

        // Test 2: unchanged data sends nothing
        base = frames[0];
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy[0]) n++;
        end
        check("idle_busy_cycles", n, 0);
        check("idle_no_frames", frames[0], base);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            base = frames[0];
            data[0] = vecs[i].dat;
            for (int j = 0; j < vecs[i].nfr; j++) q0.push_back(vecs[i].dat);
            if (vecs[i].frc) pulse_force(0);
            wait_frames(0, base + vecs[i].nfr, 100);
            repeat (25) @(negedge clk);
            check($sformatf("vec%0d_frames", i), frames[0] - base, vecs[i].nfr);
            check($sformatf("vec%0d_shown", i), shown[0], vecs[i].exp_shown);
        end

        // Test 3: data changes mid-frame
        base = frames[0];
        data[0] = 8'hA5;
        q0.push_back(8'hA5);
        q0.push_back(8'h3C);
        n = 0;
        while (nbits[0] < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midframe_reached_bit3", nbits[0], 3);
        data[0] = 8'h3C;
        wait_frames(0, base + 2, 200);
        check("midframe_gap", last_gap[0], 2);
        check("midframe_shown", shown[0], 8'h3C);

        // Test 4: several forces during a busy frame give one extra frame
        repeat (5) @(negedge clk);
        base = frames[0];
        q0.push_back(8'h3C);
        q0.push_back(8'h3C);
        pulse_force(0);
        n = 0;
        while (!busy[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("force_busy", busy[0], 1'b1);
        for (int j = 0; j < 3; j++) begin
            pulse_force(0);
            @(negedge clk);
        end
        wait_frames(0, base + 2, 200);
        repeat (40) @(negedge clk);
        check("force_total_frames", frames[0] - base, 2);

        // Test 6: reset mid-frame abandons the frame
        data[0] = 8'h96;
        q0.push_back(8'h96);
        n = 0;
        while (nbits[0] < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_bit5", nbits[0], 5);
        #2 rst_n[0] = 1'b0;
        #1 check("rst_midframe_outs", {busy[0], done[0], sclk[0], sdat[0], slat[0], shown[0]}, 32'd0);
        repeat (3) @(negedge clk);
        void'(q0.pop_front());
        base = frames[0];
        q0.push_back(8'h96);
        rst_n[0] = 1'b1;
        wait_frames(0, base + 1, 100);
        check("rst_resend_shown", shown[0], 8'h96);

        // Test 5: slow divider, LSB first
        q1.push_back(8'h01);
        rst_n[1] = 1'b1;
        wait_frames(1, 1, 200);
        check("lsb_first_bit", first_bit[1], 1'b1);
        check("slow_shown", shown[1], 8'h01);

        repeat (30) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
